// File: rtl/vend_pkg.sv
// Shared types and constants for the vending credit sequencer.
package vend_pkg;

    typedef enum logic [1:0] {
        COLLECT,
        VEND,
        DISP,
        CHANGE
    } state_t;

    localparam logic COIN_NICKEL = 1'b0;
    localparam logic COIN_DIME   = 1'b1;

    localparam int NICKEL_UNITS = 1;
    localparam int DIME_UNITS   = 2;

endpackage

// File: rtl/credit_counter.sv
// Up/down credit counter stepping by 1 or 2 units; wraps modulo 2^W and
// relies on its controller to keep it inside range.
module credit_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         up_down,
    input  logic         inc2,
    output logic [W-1:0] credit
);

    logic [W-1:0] step;

    assign step = inc2 ? W'(2) : W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= '0;
        end else if (en) begin
            credit <= up_down ? (credit - step) : (credit + step);
        end
    end

endmodule

// File: rtl/vend_credit_ctrl.sv
// Credit sequencer: collects coins, debits the price, pulses dispense and
// pays change. Define VEND_AUTO_CHANGE_EN to pay residual credit after a vend.
module vend_credit_ctrl
    import vend_pkg::*;
#(
    parameter int W     = 4,
    parameter int PRICE = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         coin_valid,
    input  logic         coin_type,
    output logic         coin_ready,
    input  logic         cancel,
    output logic         dispense,
    output logic         change_valid,
    output logic         change_type,
    input  logic         change_ack,
    output logic [W-1:0] credit,
    output logic         busy,
    output state_t       state
);

    localparam logic [W-1:0] PRICE_U    = W'(PRICE);
    localparam logic [W-1:0] ONE_U      = W'(NICKEL_UNITS);
    localparam logic [W-1:0] TWO_U      = W'(DIME_UNITS);
    localparam logic [W-1:0] COIN_LIMIT = W'((1 << W) - 3);

    state_t       state_next;
    logic [W-1:0] remaining;
    logic [W-1:0] remaining_next;
    logic [W-1:0] vend_step;
    logic [W-1:0] change_step;
    logic         cnt_en;
    logic         cnt_down;
    logic         cnt_inc2;

    credit_counter #(.W(W)) u_counter (
        .clk     (clk),
        .rst     (rst),
        .en      (cnt_en),
        .up_down (cnt_down),
        .inc2    (cnt_inc2),
        .credit  (credit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= COLLECT;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    assign vend_step   = (remaining >= TWO_U) ? TWO_U : ONE_U;
    assign change_step = (credit >= TWO_U) ? TWO_U : ONE_U;
    assign busy        = (state != COLLECT);

    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        cnt_en         = 1'b0;
        cnt_down       = 1'b0;
        cnt_inc2       = 1'b0;
        coin_ready     = 1'b0;
        dispense       = 1'b0;
        change_valid   = 1'b0;
        change_type    = COIN_NICKEL;
        case (state)
            COLLECT: begin
                // Refusing coins above 2^W-3 keeps a dime from wrapping the counter.
                coin_ready = !cancel && (credit <= COIN_LIMIT);
                if (coin_valid && coin_ready) begin
                    cnt_en   = 1'b1;
                    cnt_inc2 = (coin_type == COIN_DIME);
                end
                if (credit >= PRICE_U) begin
                    state_next     = VEND;
                    remaining_next = PRICE_U;
                end else if (cancel && (credit != '0)) begin
                    state_next = CHANGE;
                end
            end
            VEND: begin
                cnt_en         = 1'b1;
                cnt_down       = 1'b1;
                cnt_inc2       = (vend_step == TWO_U);
                remaining_next = remaining - vend_step;
                if (remaining == vend_step) begin
                    state_next = DISP;
                end
            end
            DISP: begin
                dispense = 1'b1;
`ifdef VEND_AUTO_CHANGE_EN
                state_next = (credit != '0) ? CHANGE : COLLECT;
`else
                state_next = COLLECT;
`endif
            end
            CHANGE: begin
                if (credit != '0) begin
                    change_valid = 1'b1;
                    change_type  = (change_step == TWO_U) ? COIN_DIME : COIN_NICKEL;
                    if (change_ack) begin
                        cnt_en   = 1'b1;
                        cnt_down = 1'b1;
                        cnt_inc2 = (change_step == TWO_U);
                        if (credit == change_step) begin
                            state_next = COLLECT;
                        end
                    end
                end else begin
                    state_next = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

endmodule

// File: doc/vend_credit_ctrl.md
# vend_credit_ctrl

Credit sequencer for the vending machine datapath. Accepts coin events, drives the shared up/down credit counter (steps of ±1 or ±2 units), and sequences the vend debit, the dispense pulse and the change/refund payout. It is the only block that commands the credit counter. It sits between the coin-acceptor front end and the dispenser/change-hopper outputs.

## Interface
- W, 4: credit counter width in units (1 unit = nickel, 2 units = dime)
- PRICE, 3: item price in units; legal range 1..2^W-1
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- coin_valid  in  1  coin present this cycle
- coin_type  in  1  0 = nickel (+1), 1 = dime (+2)
- coin_ready  out  1  coin accepted when coin_valid && coin_ready at a clk edge
- cancel  in  1  refund request
- dispense  out  1  one-cycle pulse, release one item
- change_valid  out  1  change coin request to the hopper
- change_type  out  1  0 = nickel, 1 = dime
- change_ack  in  1  hopper took the coin; completes the handshake that cycle
- credit  out  W  current credit, taken directly from the counter
- busy  out  1  high in every state except COLLECT

## Operation
- The FSM has four states: COLLECT, VEND, DISP, CHANGE.
- Reset values:
  - state = COLLECT, credit = 0, remaining = 0.
  - All outputs are 0 except coin_ready, which follows its equation and is therefore high.
- COLLECT:
  - coin_ready = !cancel && credit <= 2^W-3.
  - On an accepted coin, the counter steps up by 1 or 2.
  - If the registered credit is >= PRICE, the next state is VEND with remaining = PRICE.
  - Otherwise, if cancel is high and credit > 0, the next state is CHANGE.
  - cancel with credit = 0 is ignored.
- Priority when cancel is high in a cycle where credit >= PRICE: VEND wins. The debit still happens. Any residual credit is paid out afterwards per the configured behaviour.
- VEND:
  - One counter step per cycle: step = 2 if remaining >= 2, else 1.
  - credit -= step and remaining -= step.
  - When remaining == step, the next state is DISP.
  - coin_ready = 0. cancel is ignored.
- DISP:
  - dispense = 1 for exactly this one cycle.
  - The next state is CHANGE if auto-change is enabled and credit > 0, otherwise COLLECT.
- CHANGE:
  - change_valid = 1 while credit > 0. change_type = (credit >= 2).
  - change_valid and change_type hold stable until change_ack.
  - On change_ack, the counter steps down by 2 or 1 per change_type.
  - When credit reaches 0, the next state is COLLECT.
  - change_ack while change_valid = 0 is ignored.
- Counter width rule: the counter wraps modulo 2^W. The controller guarantees no wrap: it never increments above 2^W-1 and never decrements below 0.

## Timing
- Coin to credit: credit updates at the same edge the coin is accepted.
- Credit >= PRICE is evaluated on registered credit, so VEND is entered one cycle after the coin edge.
- Vend latency for PRICE = 3: two VEND cycles (−2, −1), then one DISP cycle. dispense is high in the 4th cycle after the final coin edge.
- Change latency: one coin per change_ack cycle, no minimum gap. Back-to-back acks drain 2 units per cycle.
- Reset is asynchronous from any state: mid-VEND or mid-CHANGE, credit is cleared and no dispense is emitted.

## Configuration
- VEND_AUTO_CHANGE_EN defined:
  - After DISP with residual credit > 0, the FSM goes to CHANGE and pays out the residual.
- VEND_AUTO_CHANGE_EN undefined:
  - After DISP, the FSM always returns to COLLECT and residual credit is retained toward the next purchase.
  - Change is paid only on cancel.

## Structure
- Package vend_pkg holds:
  - the state enum {COLLECT, VEND, DISP, CHANGE};
  - coin encodings COIN_NICKEL = 0 and COIN_DIME = 1;
  - unit values NICKEL_UNITS = 1 and DIME_UNITS = 2.
- Sub-module credit_counter:
  - Parameter W. Ports clk, rst, en, up_down (0 = up), inc2 (step 2 vs 1), credit[W-1:0].
  - Async reset to 0; holds its value when en = 0.
- The FSM and the remaining register live in vend_credit_ctrl. credit_counter is instantiated once.

## Test plan
- Vend with auto-change, W = 4, PRICE = 3, VEND_AUTO_CHANGE_EN defined:
  - Stimulus: dime, dime.
  - Response: credit 2 → 4; VEND steps credit 4 → 2 → 1; one dispense pulse; change_valid with change_type = 0; after ack, credit 0 and busy = 0.
- Cancel refund: with credit = 2, assert cancel.
  - Response: CHANGE issues one dime; after ack, credit 0; dispense is never asserted.
- Coin/cancel collision: coin_valid and cancel together at credit 1.
  - Response: coin_ready = 0, credit stays 1 until refunded, one nickel is paid.
- Overflow guard: W = 4, PRICE = 15, credit 14.
  - Response: coin_ready = 0 and a dime is not accepted.
  - At credit 13 a dime is accepted, credit becomes 15 and the vend starts.
- Hopper stall: hold change_ack low for 5 cycles.
  - Response: change_valid and change_type stay stable and credit is unchanged.
- Reset mid-VEND, then a macro-off run:
  - rst at the first VEND cycle: credit 0, state COLLECT, no dispense.
  - Separately, with VEND_AUTO_CHANGE_EN undefined: dime, dime, then vend leaves credit 1 in COLLECT with no change_valid.
